// File: rtl/zbt_port_arbiter.sv
// ---------------------------------------------------------------------------
// zbt_port_arbiter
//
// Two-client front end for the ZBT driver. Ports A and B each present one
// read or write request at a time. A combinational round-robin arbiter
// grants at most one request per cycle. The granted request is registered
// onto the driver interface in the following cycle. Each cycle drives one
// ZBT cycle: zbt_cen stays high whenever reset is low, and a cycle with no
// grant becomes a dummy read. A {valid, port} tag pipeline follows every
// issued cycle through the ZBT read latency. The tag steers the returned
// word to the client that asked for it.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request, held until a_gnt
//   a_gnt                 port A accepted this cycle (combinational)
//   a_rvalid              one-cycle strobe: rdata carries a port A read
//   b_*                   same as port A, for port B
//   rdata                 shared read-return data, held between captures
//   zbt_cen/we/addr/wdata command to the ZBT driver
//   zbt_rdata             read data from the ZBT driver
//
// Read timing: a read granted in cycle N is on the driver in N+1. Its data
// arrives on zbt_rdata in N+1+READ_LAT, is captured at the end of that
// cycle, and is presented with x_rvalid in N+2+READ_LAT.
// ---------------------------------------------------------------------------
module zbt_port_arbiter #(
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned DATA_W   = 36,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,

    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,

    output logic [DATA_W-1:0] rdata,

    output logic              zbt_cen,
    output logic              zbt_we,
    output logic [ADDR_W-1:0] zbt_addr,
    output logic [DATA_W-1:0] zbt_wdata,
    input  logic [DATA_W-1:0] zbt_rdata
);

    // Tag slot READ_LAT is the one whose data is on zbt_rdata this cycle.
    localparam int unsigned TagDepth = READ_LAT + 1;

    typedef enum logic {
        PortA = 1'b0,
        PortB = 1'b1
    } port_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    port_e                rr_q, rr_d;

    logic                 cen_q, cen_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;

    logic [TagDepth-1:0]  tag_valid_q, tag_valid_d;
    logic [TagDepth-1:0]  tag_port_q, tag_port_d;

    logic                 a_rvalid_q, a_rvalid_d;
    logic                 b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                 grant;
    port_e                grant_port;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        // Reset is checked here so no grant can leak out during reset.
        if (!reset) begin
            if (a_req && (!b_req || rr_q == PortA)) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        grant      = a_gnt | b_gnt;
        grant_port = b_gnt ? PortB : PortA;
        sel_we     = b_gnt ? b_we    : a_we;
        sel_addr   = b_gnt ? b_addr  : a_addr;
        sel_wdata  = b_gnt ? b_wdata : a_wdata;
    end

    // The pointer moves away from whichever port was just served. It stays
    // put on cycles with no grant.
    always_comb begin
        rr_d = rr_q;
        if (grant) begin
            rr_d = (grant_port == PortA) ? PortB : PortA;
        end
    end

    // ------------------------------------------------------------------
    // Issue stage
    // ------------------------------------------------------------------
    always_comb begin
        cen_d   = 1'b1;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (grant) begin
            we_d    = sel_we;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Tag pipeline and read return
    // ------------------------------------------------------------------
    always_comb begin
        tag_valid_d    = tag_valid_q << 1;
        tag_port_d     = tag_port_q << 1;
        tag_valid_d[0] = grant & ~sel_we;
        tag_port_d[0]  = grant_port;
    end

    always_comb begin
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        rdata_d    = rdata_q;
        if (tag_valid_q[READ_LAT]) begin
            rdata_d = zbt_rdata;
            if (tag_port_q[READ_LAT] == PortB) begin
                b_rvalid_d = 1'b1;
            end else begin
                a_rvalid_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q        <= PortA;
            cen_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            tag_valid_q <= '0;
            tag_port_q  <= '0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rr_q        <= rr_d;
            cen_q       <= cen_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            rdata_q     <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign zbt_cen   = cen_q;
    assign zbt_we    = we_q;
    assign zbt_addr  = addr_q;
    assign zbt_wdata = wdata_q;
    assign a_rvalid  = a_rvalid_q;
    assign b_rvalid  = b_rvalid_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_zbt_port_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for zbt_port_arbiter. A driver/SRAM model answers the ZBT
// interface with READ_LAT latency. The reference model tracks memory
// contents in grant order, the round-robin choice and the expected issue
// stage. It pushes expected read returns into a scoreboard queue, and an
// independent monitor pops and compares them.
// Addresses are drawn from the low 16 and the top 16 words, so both model
// memories stay small and still include address 0 and 19'h7FFFF.
// ---------------------------------------------------------------------------
module tb_zbt_port_arbiter;
    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 36;
    localparam int READ_LAT = 2;
    localparam int RET_LAT  = READ_LAT + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              a_req, a_we, b_req, b_we;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_wdata, b_wdata;
    logic              a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DATA_W-1:0] rdata;
    logic              zbt_cen, zbt_we;
    logic [ADDR_W-1:0] zbt_addr;
    logic [DATA_W-1:0] zbt_wdata, zbt_rdata;

    zbt_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rvalid  (b_rvalid),
        .rdata     (rdata),
        .zbt_cen   (zbt_cen),
        .zbt_we    (zbt_we),
        .zbt_addr  (zbt_addr),
        .zbt_wdata (zbt_wdata),
        .zbt_rdata (zbt_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int idx(input logic [ADDR_W-1:0] a);
        return int'({a[ADDR_W-1], a[3:0]});
    endfunction

    function automatic logic [DATA_W-1:0] preload(input int i);
        if (i >= 16) return 36'hB00 + DATA_W'(i - 16);
        return 36'hA0 + DATA_W'(i);
    endfunction

    // ---------------- driver + SRAM model ----------------
    logic [DATA_W-1:0] drv_mem [32];
    logic [DATA_W-1:0] rd_p0, rd_p1;
    bit                mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) drv_mem[i] <= preload(i);
            mem_init <= 1'b1;
        end else if (zbt_cen && zbt_we) begin
            drv_mem[idx(zbt_addr)] <= zbt_wdata;
        end
        rd_p0 <= drv_mem[idx(zbt_addr)];
        rd_p1 <= rd_p0;
    end
    assign zbt_rdata = rd_p1;

    // ---------------- scoreboard ----------------
    typedef struct {
        bit                port;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;
    exp_t sbq[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("rvalid_both", {63'd0, a_rvalid & b_rvalid}, 64'd0);
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                chk("rvalid_missing", cyc, sbq[0].due);
                void'(sbq.pop_front());
            end
            if (a_rvalid || b_rvalid) begin
                if (sbq.size() == 0) begin
                    chk("rvalid_unexpected", {62'd0, a_rvalid, b_rvalid}, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("rvalid_port", {63'd0, b_rvalid}, {63'd0, e.port});
                    chk("rdata", rdata, e.data);
                    chk("rvalid_cycle", cyc, e.due);
                end
            end
        end
    end

    // ---------------- reference model + stimulus ----------------
    logic [DATA_W-1:0] ref_mem [32];
    bit                rr_m;       // 0 = A preferred on contention
    logic              exp_cen, exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_wdata;
    bit                last_ga, last_gb;

    task automatic apply_grant(input bit port, input logic we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wd);
        exp_t e;
        exp_we = we;
        exp_addr = addr;
        exp_wdata = wd;
        if (we) begin
            ref_mem[idx(addr)] = wd;
        end else begin
            e.port = port;
            e.data = ref_mem[idx(addr)];
            e.due  = cyc + RET_LAT;
            sbq.push_back(e);
        end
    endtask

    // Inputs are set just after a posedge; this samples at the next negedge,
    // then returns 1 time unit after the following posedge.
    task automatic cycle();
        bit ga_m, gb_m;
        @(negedge clk);
        if (reset) begin
            chk("rst_zbt_cen", {63'd0, zbt_cen}, 64'd0);
            chk("rst_zbt_we", {63'd0, zbt_we}, 64'd0);
            chk("rst_zbt_addr", zbt_addr, 64'd0);
            chk("rst_zbt_wdata", zbt_wdata, 64'd0);
            chk("rst_rvalid", {62'd0, a_rvalid, b_rvalid}, 64'd0);
            chk("rst_rdata", rdata, 64'd0);
        end else begin
            chk("zbt_cen", {63'd0, zbt_cen}, {63'd0, exp_cen});
            chk("zbt_we", {63'd0, zbt_we}, {63'd0, exp_we});
            chk("zbt_addr", zbt_addr, exp_addr);
            chk("zbt_wdata", zbt_wdata, exp_wdata);
        end
        ga_m = 1'b0;
        gb_m = 1'b0;
        if (!reset) begin
            if (a_req && b_req) begin
                if (rr_m) gb_m = 1'b1;
                else ga_m = 1'b1;
            end else if (a_req) begin
                ga_m = 1'b1;
            end else if (b_req) begin
                gb_m = 1'b1;
            end
        end
        chk("gnt", {62'd0, a_gnt, b_gnt}, {62'd0, ga_m, gb_m});
        if (reset) begin
            rr_m = 1'b0;
            exp_cen = 1'b0;
            exp_we = 1'b0;
            exp_addr = '0;
            exp_wdata = '0;
        end else begin
            exp_cen = 1'b1;
            exp_we = 1'b0;
            if (ga_m) begin
                rr_m = 1'b1;
                apply_grant(1'b0, a_we, a_addr, a_wdata);
            end else if (gb_m) begin
                rr_m = 1'b0;
                apply_grant(1'b1, b_we, b_addr, b_wdata);
            end
        end
        @(posedge clk);
        #1;
        if (ga_m) a_req = 1'b0;
        if (gb_m) b_req = 1'b0;
        last_ga = ga_m;
        last_gb = gb_m;
    endtask

    task automatic set_req(input bit port, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wd);
        if (port) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end
    endtask

    task automatic issue(input bit port, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wd);
        int n;
        bit got;
        n = 0;
        got = 1'b0;
        set_req(port, we, addr, wd);
        while (!got && n < 8) begin
            cycle();
            n++;
            got = port ? last_gb : last_ga;
        end
        if (!got) chk("grant_timeout", n, 64'd0);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a = a | 19'h7FFF0;
        return a;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        return {4'($urandom_range(0, 15)), 32'($urandom)};
    endfunction

    initial begin
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = preload(i);
        rr_m = 1'b0;
        exp_cen = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
        last_ga = 1'b0; last_gb = 1'b0;

        @(posedge clk);
        #1;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        // Write then read back on port A.
        issue(1'b0, 1'b1, 19'd5, 36'h0_1234_5678);
        cycle();
        issue(1'b0, 1'b0, 19'd5, '0);
        repeat (6) cycle();

        // Both ports hold reads: grants alternate.
        for (int i = 0; i < 8; i++) begin
            if (!a_req) set_req(1'b0, 1'b0, ADDR_W'(i), '0);
            if (!b_req) set_req(1'b1, 1'b0, ADDR_W'(i + 8), '0);
            cycle();
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (6) cycle();

        // Back-to-back B reads of preloaded words.
        for (int k = 0; k < 4; k++) issue(1'b1, 1'b0, ADDR_W'(k), '0);
        repeat (6) cycle();

        // Reset with reads in flight: nothing may return.
        issue(1'b0, 1'b0, 19'd3, '0);
        issue(1'b0, 1'b0, 19'd4, '0);
        reset = 1'b1;
        sbq.delete();
        cycle();
        reset = 1'b0;
        repeat (10) cycle();

        // Idle: dummy reads only.
        repeat (20) cycle();

        // Top address is distinct from address 0.
        issue(1'b0, 1'b1, 19'h7FFFF, 36'h9_8765_4321);
        issue(1'b1, 1'b0, 19'h7FFFF, '0);
        issue(1'b0, 1'b0, 19'h00000, '0);
        repeat (6) cycle();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if (!a_req && $urandom_range(0, 99) < 60)
                set_req(1'b0, 1'($urandom_range(0, 1)), rand_addr(), rand_data());
            if (!b_req && $urandom_range(0, 99) < 60)
                set_req(1'b1, 1'($urandom_range(0, 1)), rand_addr(), rand_data());
            cycle();
        end
        a_req = 1'b0;
        b_req = 1'b0;
        repeat (8) cycle();
        chk("sb_drained", sbq.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
